rx_lane_deskew: RTL and testbench
=================================

RX_LANE_DESKEW -- requirements
Module: rx_lane_deskew

Interface
REQ-001 Parameter: MAX_SKEW, default 3, maximum tolerated lane-to-lane skew in clk_4f cycles.
REQ-002 clk_4f  input  1  the only clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 active_0 / active_1  input  1 each  lane synchronised flag from the serial-to-parallel stage.
REQ-005 valid_0 / valid_1  input  1 each  lane byte valid.
REQ-006 data_0 / data_1  input  8 each  lane byte; meaningful only when the matching valid is high.
REQ-007 data_out_0 / data_out_1  output  8 each  deskewed lane bytes, registered.
REQ-008 valid_out  output  1  aligned pair valid on both data_out lanes.
REQ-009 link_up  output  1  high while in LINKED.
REQ-010 deskew_err  output  1  one-cycle pulse on an alignment failure.
REQ-011 state  output  2  IDLE=0, TRAIN=1, LINKED=2, RECOVER=3.

Function
REQ-012 Each lane SHALL keep a delay line of byte+valid.
- tap[0] = current input.
- tap[k] = input k cycles earlier, for k = 1..MAX_SKEW.
- Delay lines shift every cycle in every state.
REQ-013 Each lane SHALL hold a delay-select register delay_x in 0..MAX_SKEW.
- Both registers clear in IDLE and RECOVER, and on entry to TRAIN.
REQ-014 IDLE -> TRAIN when active_0 and active_1 are both high; otherwise stay in IDLE.
REQ-015 TRAIN, both lanes' first valid in the same cycle:
- skew = 0, both delays = 0.
- Go to LINKED.
REQ-016 TRAIN, only one lane's first valid:
- Mark that lane as early.
- Start the skew counter at 0; it increments each following cycle.
REQ-017 TRAIN, the late lane's first valid arrives at counter value k <= MAX_SKEW:
- Early lane delay = k, late lane delay = 0.
- Go to LINKED.
REQ-018 TRAIN, counter reaches MAX_SKEW+1 without the late lane's valid:
- Pulse deskew_err for one cycle.
- Go to RECOVER.
REQ-019 RECOVER -> TRAIN once valid_0 and valid_1 are both low in the same cycle; otherwise stay in RECOVER.
REQ-020 Aligned signals: a_x = tap[delay_x] of lane x, with aligned valid av_x.
- data_out_x <= a_x data every cycle.
- valid_out <= av_0 & av_1 & (LINKED, or transitioning into LINKED this cycle).
REQ-021 The first aligned pair SHALL appear at the outputs, with valid_out high, on cycle T+1, where T is the cycle the late lane's (or both lanes') first valid was sampled.
REQ-022 Steady-state latency: lane x input to output = delay_x + 1 cycles.
REQ-023 LINKED with av_0 != av_1 (aligned valid mismatch):
- valid_out low and deskew_err high the next cycle.
- Go to TRAIN with delays cleared.
REQ-024 LINKED with av_0 and av_1 both low: valid_out low, stay in LINKED.
REQ-025 active_0 or active_1 low in any state other than IDLE:
- Go to IDLE.
- link_up and valid_out low the next cycle.
- This has priority over every other transition, including a mismatch in the same cycle.
REQ-026 data_out_x SHALL be don't-care whenever valid_out is low.

Reset
REQ-027 While reset is high at a clock edge:
- state = IDLE, delays = 0, skew counter = 0.
- Delay-line valid bits = 0.
- data_out_0/1 = 8'h00, valid_out = 0, link_up = 0, deskew_err = 0.
REQ-028 Reset asserted mid-LINKED SHALL abort alignment at once.
- After release, training restarts from IDLE.
- No stale pair from the delay lines may produce valid_out.

Verification
REQ-029 Both lanes active, lane 0 valid at cycle 10 and lane 1 valid at cycle 12, bytes 0x11/0x22 onward -> delay_0 = 2, delay_1 = 0; first pair 0x11/0x22 at cycle 13 with valid_out = 1 and link_up = 1.
REQ-030 Both lanes' first valid in the same cycle -> delays 0/0; outputs equal inputs 1 cycle later.
REQ-031 Lane 1 valid 4 cycles after lane 0 (MAX_SKEW = 3) -> deskew_err pulses once; state = RECOVER; valid_out stays 0; retrain succeeds after both valids drop low.
REQ-032 In LINKED, drop valid_1 for one cycle while valid_0 stays high -> deskew_err pulse, valid_out = 0, state = TRAIN.
REQ-033 In LINKED, drop active_0 -> state = IDLE, link_up = 0 next cycle; a reset pulse mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rx_lane_deskew.sv
// Two-lane receive deskew: per-lane byte delay lines with a trained tap select so that
// both lanes emit their bytes aligned, plus a small link FSM (IDLE/TRAIN/LINKED/RECOVER).
module rx_lane_deskew #(
  parameter int unsigned MAX_SKEW = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       active_0,
  input  logic       active_1,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out,
  output logic       link_up,
  output logic       deskew_err,
  output logic [1:0] state
);

  localparam int unsigned DW = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;
  localparam int unsigned CW = $clog2(MAX_SKEW + 2);
  localparam logic [CW-1:0] CntLimit = CW'(MAX_SKEW + 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StTrain   = 2'd1,
    StLinked  = 2'd2,
    StRecover = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] delay_0_q, delay_0_d;
  logic [DW-1:0] delay_1_q, delay_1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          early_seen_q, early_seen_d;
  // 0: lane 0 arrived first, 1: lane 1 arrived first
  logic          early_lane_q, early_lane_d;

  logic [MAX_SKEW:1][7:0] dl_data_0_q, dl_data_1_q;
  logic [MAX_SKEW:1]      dl_valid_0_q, dl_valid_1_q;

  logic [MAX_SKEW:0][7:0] tap_data_0, tap_data_1;
  logic [MAX_SKEW:0]      tap_valid_0, tap_valid_1;

  logic [DW-1:0] sel_0, sel_1;
  logic          av_0, av_1;
  logic [7:0]    a_data_0, a_data_1;

  logic          late_valid;
  logic          link_now;
  logic [DW-1:0] link_delay_0, link_delay_1;

  logic          valid_out_d;
  logic          err_d;

  assign tap_data_0  = {dl_data_0_q, data_0};
  assign tap_data_1  = {dl_data_1_q, data_1};
  assign tap_valid_0 = {dl_valid_0_q, valid_0};
  assign tap_valid_1 = {dl_valid_1_q, valid_1};

  // Link decision while training; independent of the aligned valids to avoid a comb loop.
  always_comb begin
    link_now     = 1'b0;
    link_delay_0 = '0;
    link_delay_1 = '0;
    late_valid   = early_lane_q ? valid_0 : valid_1;
    if (!early_seen_q) begin
      link_now = valid_0 & valid_1;
    end else if ((cnt_q != CntLimit) && late_valid) begin
      link_now = 1'b1;
      if (early_lane_q) begin
        link_delay_1 = DW'(cnt_q);
      end else begin
        link_delay_0 = DW'(cnt_q);
      end
    end
  end

  // Use the freshly trained delays in the cycle the link comes up so the first pair
  // is already aligned at the output one cycle later.
  always_comb begin
    sel_0    = (state_q == StTrain) ? link_delay_0 : delay_0_q;
    sel_1    = (state_q == StTrain) ? link_delay_1 : delay_1_q;
    av_0     = tap_valid_0[sel_0];
    av_1     = tap_valid_1[sel_1];
    a_data_0 = tap_data_0[sel_0];
    a_data_1 = tap_data_1[sel_1];
  end

  always_comb begin
    state_d      = state_q;
    delay_0_d    = delay_0_q;
    delay_1_d    = delay_1_q;
    cnt_d        = cnt_q;
    early_seen_d = early_seen_q;
    early_lane_d = early_lane_q;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        delay_0_d    = '0;
        delay_1_d    = '0;
        cnt_d        = '0;
        early_seen_d = 1'b0;
        if (active_0 && active_1) begin
          state_d = StTrain;
        end
      end

      StTrain: begin
        if (link_now) begin
          delay_0_d = link_delay_0;
          delay_1_d = link_delay_1;
          state_d   = StLinked;
        end else if (!early_seen_q) begin
          if (valid_0 || valid_1) begin
            early_seen_d = 1'b1;
            early_lane_d = valid_1;
            cnt_d        = CW'(1);
          end
        end else if (cnt_q == CntLimit) begin
          err_d   = 1'b1;
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      StLinked: begin
        if (av_0 != av_1) begin
          err_d        = 1'b1;
          state_d      = StTrain;
          delay_0_d    = '0;
          delay_1_d    = '0;
          cnt_d        = '0;
          early_seen_d = 1'b0;
        end
      end

      StRecover: begin
        delay_0_d    = '0;
        delay_1_d    = '0;
        cnt_d        = '0;
        early_seen_d = 1'b0;
        if (!valid_0 && !valid_1) begin
          state_d = StTrain;
        end
      end

      default: state_d = StIdle;
    endcase

    // Losing either lane overrides everything, including a same-cycle mismatch.
    if ((state_q != StIdle) && !(active_0 && active_1)) begin
      state_d      = StIdle;
      err_d        = 1'b0;
      delay_0_d    = '0;
      delay_1_d    = '0;
      cnt_d        = '0;
      early_seen_d = 1'b0;
    end

    valid_out_d = av_0 & av_1 & (state_d == StLinked);
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q      <= StIdle;
      delay_0_q    <= '0;
      delay_1_q    <= '0;
      cnt_q        <= '0;
      early_seen_q <= 1'b0;
      early_lane_q <= 1'b0;
      dl_data_0_q  <= '0;
      dl_data_1_q  <= '0;
      dl_valid_0_q <= '0;
      dl_valid_1_q <= '0;
      data_out_0   <= 8'h00;
      data_out_1   <= 8'h00;
      valid_out    <= 1'b0;
      deskew_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_0_q    <= delay_0_d;
      delay_1_q    <= delay_1_d;
      cnt_q        <= cnt_d;
      early_seen_q <= early_seen_d;
      early_lane_q <= early_lane_d;
      dl_data_0_q  <= tap_data_0[MAX_SKEW-1:0];
      dl_data_1_q  <= tap_data_1[MAX_SKEW-1:0];
      dl_valid_0_q <= tap_valid_0[MAX_SKEW-1:0];
      dl_valid_1_q <= tap_valid_1[MAX_SKEW-1:0];
      data_out_0   <= a_data_0;
      data_out_1   <= a_data_1;
      valid_out    <= valid_out_d;
      deskew_err   <= err_d;
    end
  end

  assign link_up = (state_q == StLinked);
  assign state   = state_q;

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Scoreboard bench for rx_lane_deskew: expected aligned pairs are queued as the late
// lane's byte is driven and popped whenever valid_out is seen.
module tb_rx_lane_deskew;

  logic       clk_4f;
  logic       reset;
  logic       active_0, active_1;
  logic       valid_0, valid_1;
  logic [7:0] data_0, data_1;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out, link_up, deskew_err;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int err_base;
  logic [15:0] sb_q[$];

  rx_lane_deskew #(.MAX_SKEW(3)) dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .active_0   (active_0),
    .active_1   (active_1),
    .valid_0    (valid_0),
    .valid_1    (valid_1),
    .data_0     (data_0),
    .data_1     (data_1),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .valid_out  (valid_out),
    .link_up    (link_up),
    .deskew_err (deskew_err),
    .state      (state)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of lane inputs, then return 1 time unit after the sampling edge.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    valid_0 = v0;
    data_0  = d0;
    valid_1 = v1;
    data_1  = d1;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  always @(negedge clk_4f) begin
    if (deskew_err) err_pulses++;
    if (valid_out) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", {31'd0, valid_out}, 32'd0);
      end else begin
        check_eq("pair", {16'd0, data_out_0, data_out_1}, {16'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    reset    = 1'b1;
    active_0 = 1'b0;
    active_1 = 1'b0;
    idle_step();
    idle_step();
    check_eq("rst_state", {30'd0, state}, 32'd0);
    check_eq("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("rst_link_up", {31'd0, link_up}, 32'd0);
    check_eq("rst_err", {31'd0, deskew_err}, 32'd0);
    check_eq("rst_data", {16'd0, data_out_0, data_out_1}, 32'd0);
    reset = 1'b0;
    idle_step();
    check_eq("idle_hold", {30'd0, state}, 32'd0);

    // Skewed link: lane 1 two cycles behind lane 0.
    active_0 = 1'b1;
    active_1 = 1'b1;
    idle_step();
    check_eq("a_train", {30'd0, state}, 32'd1);
    err_base = err_pulses;
    for (int s = 0; s < 10; s++) begin
      logic       v0, v1;
      logic [7:0] d0, d1;
      v0 = (s < 8);
      d0 = 8'h11 + 8'(s);
      v1 = (s >= 2);
      d1 = 8'h22 + 8'(s - 2);
      if (v1) sb_q.push_back({8'h11 + 8'(s - 2), d1});
      step(v0, d0, v1, d1);
      if (s == 1) check_eq("a_no_early_valid", {31'd0, valid_out}, 32'd0);
      if (s == 2) begin
        check_eq("a_first_valid", {31'd0, valid_out}, 32'd1);
        check_eq("a_link_up", {31'd0, link_up}, 32'd1);
      end
    end
    idle_step();
    idle_step();
    check_eq("a_idle_linked", {30'd0, state}, 32'd2);
    check_eq("a_idle_valid", {31'd0, valid_out}, 32'd0);

    // Lane drop with a simultaneous aligned-valid mismatch: drop wins, no error.
    active_0 = 1'b0;
    step(1'b1, 8'hEE, 1'b1, 8'hEE);
    check_eq("drop_state", {30'd0, state}, 32'd0);
    check_eq("drop_link_up", {31'd0, link_up}, 32'd0);
    check_eq("drop_valid", {31'd0, valid_out}, 32'd0);
    idle_step();
    check_eq("drop_no_err", err_pulses - err_base, 0);

    // Zero skew, then a one-cycle dropout on lane 1.
    active_0 = 1'b1;
    idle_step();
    check_eq("c_train", {30'd0, state}, 32'd1);
    for (int s = 0; s < 5; s++) begin
      sb_q.push_back({8'h40 + 8'(s), 8'h80 + 8'(s)});
      step(1'b1, 8'h40 + 8'(s), 1'b1, 8'h80 + 8'(s));
      if (s == 0) check_eq("c_first_valid", {31'd0, valid_out}, 32'd1);
    end
    step(1'b1, 8'h45, 1'b0, 8'h85);
    check_eq("b_err", {31'd0, deskew_err}, 32'd1);
    check_eq("b_valid", {31'd0, valid_out}, 32'd0);
    check_eq("b_state", {30'd0, state}, 32'd1);
    sb_q.push_back({8'h50, 8'h90});
    step(1'b1, 8'h50, 1'b1, 8'h90);
    check_eq("b_err_pulse", {31'd0, deskew_err}, 32'd0);
    check_eq("b_relink", {31'd0, valid_out}, 32'd1);
    idle_step();

    // Skew of MAX_SKEW+1 cycles fails and recovers.
    active_0 = 1'b0;
    active_1 = 1'b0;
    idle_step();
    active_0 = 1'b1;
    active_1 = 1'b1;
    idle_step();
    err_base = err_pulses;
    for (int s = 0; s < 7; s++) begin
      step(1'b1, 8'h30 + 8'(s), (s >= 4), 8'hC0 + 8'(s));
      if (s == 4) begin
        check_eq("d_err", {31'd0, deskew_err}, 32'd1);
        check_eq("d_recover", {30'd0, state}, 32'd3);
      end
    end
    check_eq("d_stay_recover", {30'd0, state}, 32'd3);
    idle_step();
    check_eq("d_retrain", {30'd0, state}, 32'd1);
    check_eq("d_one_pulse", err_pulses - err_base, 1);
    for (int s = 0; s < 2; s++) begin
      sb_q.push_back({8'h38 + 8'(s), 8'hC8 + 8'(s)});
      step(1'b1, 8'h38 + 8'(s), 1'b1, 8'hC8 + 8'(s));
    end
    check_eq("d_linked", {30'd0, state}, 32'd2);

    // Maximum tolerated skew with lane 1 leading.
    active_0 = 1'b0;
    idle_step();
    active_0 = 1'b1;
    idle_step();
    for (int s = 0; s < 9; s++) begin
      logic       v0, v1;
      logic [7:0] d0, d1;
      v1 = (s <= 5);
      d1 = 8'hA0 + 8'(s);
      v0 = (s >= 3);
      d0 = 8'h60 + 8'(s - 3);
      if (v0) sb_q.push_back({d0, 8'hA0 + 8'(s - 3)});
      step(v0, d0, v1, d1);
      if (s == 3) begin
        check_eq("e_first_valid", {31'd0, valid_out}, 32'd1);
        check_eq("e_linked", {30'd0, state}, 32'd2);
      end
    end

    // Reset in the middle of a linked stream.
    reset = 1'b1;
    step(1'b1, 8'h66, 1'b1, 8'hAA);
    check_eq("f_state", {30'd0, state}, 32'd0);
    check_eq("f_valid", {31'd0, valid_out}, 32'd0);
    check_eq("f_link_up", {31'd0, link_up}, 32'd0);
    check_eq("f_err", {31'd0, deskew_err}, 32'd0);
    check_eq("f_data", {16'd0, data_out_0, data_out_1}, 32'd0);
    reset = 1'b0;
    step(1'b1, 8'h70, 1'b1, 8'hB0);
    check_eq("f_no_stale", {31'd0, valid_out}, 32'd0);
    check_eq("f_train", {30'd0, state}, 32'd1);
    sb_q.push_back({8'h71, 8'hB1});
    step(1'b1, 8'h71, 1'b1, 8'hB1);
    check_eq("f_relink", {31'd0, valid_out}, 32'd1);
    idle_step();
    idle_step();

    check_eq("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
